// File: rtl/dvs_seq_pkg.sv
// Shared types and defaults for the DVS step sequencer: FSM state encoding,
// counter widths and the default code geometry.
package dvs_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        WRITE,
        HOLD,
        SETTLE,
        DONE,
        FAULT
    } state_t;

    localparam int TMO_W         = 8;
    localparam int CNT_W         = 8;
    localparam int CODE_W_DEF    = 4;
    localparam int INIT_CODE_DEF = 0;

endpackage

// File: rtl/dvs_step_sequencer_if.sv
// Request channel into the sequencer: a target code offered with valid/ready.
interface dvs_step_sequencer_if #(
    parameter int CODE_W = dvs_seq_pkg::CODE_W_DEF
);
    logic              req_valid;
    logic [CODE_W-1:0] req_code;
    logic              req_ready;

    modport master (output req_valid, output req_code, input req_ready);
    modport slave  (input req_valid, input req_code, output req_ready);
endinterface

// File: rtl/dvs_flt_filter.sv
// Debounce of the buck monitor flags: o_flt_hit asserts once the combined
// ov/uv flag has been high for DEB_CYC consecutive cycles, and stays up while it holds.
module dvs_flt_filter #(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flt,
    output logic o_flt_hit
);
    localparam int DW = $clog2(DEB_CYC + 1);

    logic [DW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_flt) begin
            r_cnt <= '0;
        end else if (r_cnt != DW'(DEB_CYC)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The current high cycle counts, so the hit lands on the DEB_CYC-th one.
    assign o_flt_hit = i_flt && (r_cnt >= DW'(DEB_CYC - 1));
endmodule

// File: rtl/dvs_step_sequencer.sv
// Ramps the buck regulator's DVS code one LSB per write toward a requested target,
// waiting for settle confirmation between steps and parking on ov/uv or settle timeout.
module dvs_step_sequencer
    import dvs_seq_pkg::*;
#(
    parameter int CODE_W      = CODE_W_DEF,
    parameter int INIT_CODE   = INIT_CODE_DEF,
    parameter int WRB_CYC     = 2,
    parameter int BLANK_CYC   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int DEB_CYC     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dvs_step_sequencer_if.slave  req_if,
    input  logic                 i_clr_fault,
    input  logic                 i_dvs_done,
    input  logic                 i_ov_dig,
    input  logic                 i_uv_dig,
    output logic [CODE_W-1:0]    o_data,
    output logic                 o_wrb,
    output logic [CODE_W-1:0]    o_cur_code,
    output logic                 o_busy,
    output logic                 o_done_pulse,
    output logic                 o_fault,
    output logic                 o_err_tmo
);
    state_t            r_state, w_state_nxt;
    logic [CODE_W-1:0] r_target, r_data, r_cur_code, w_step_code;
    logic [CNT_W-1:0]  r_cnt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_err_tmo;
    logic              w_flt_hit, w_ready, w_accept, w_settle_ok, w_tmo_hit;

    dvs_flt_filter #(.DEB_CYC(DEB_CYC)) u_flt_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flt     (i_ov_dig | i_uv_dig),
        .o_flt_hit (w_flt_hit)
    );

    assign w_ready          = (r_state == IDLE) && !w_flt_hit;
    assign req_if.req_ready = w_ready;
    assign w_accept         = req_if.req_valid && w_ready;
    assign w_settle_ok      = (r_state == SETTLE) && (r_cnt == CNT_W'(BLANK_CYC)) && i_dvs_done;
    // A settle confirmed on the last allowed cycle still counts; only a miss times out.
    assign w_tmo_hit        = (r_state == SETTLE) && (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) && !w_settle_ok;
    assign w_step_code      = (r_target > r_cur_code) ? r_cur_code + 1'b1 : r_cur_code - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_flt_hit)      w_state_nxt = FAULT;
                    else if (w_accept)  w_state_nxt = (req_if.req_code == r_cur_code) ? DONE : STEP;
            STEP:   w_state_nxt = w_flt_hit ? FAULT : WRITE;
            WRITE:  if (r_cnt == CNT_W'(WRB_CYC - 1)) w_state_nxt = HOLD;
            HOLD:   w_state_nxt = SETTLE;
            SETTLE: if (w_flt_hit || w_tmo_hit) w_state_nxt = FAULT;
                    else if (w_settle_ok)       w_state_nxt = (r_data == r_target) ? DONE : STEP;
            DONE:   w_state_nxt = w_flt_hit ? FAULT : IDLE;
            FAULT:  if (i_clr_fault && !w_flt_hit) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a latch.
    always_comb begin
        o_wrb        = 1'b1;
        o_busy       = 1'b0;
        o_done_pulse = 1'b0;
        o_fault      = 1'b0;
        o_data       = r_data;
        case (r_state)
            WRITE: begin
                o_wrb  = 1'b0;
                o_busy = 1'b1;
            end
            STEP, HOLD, SETTLE: o_busy = 1'b1;
            DONE: begin
                o_busy       = 1'b1;
                o_done_pulse = 1'b1;
            end
            FAULT: begin
                o_fault = 1'b1;
                o_data  = r_cur_code;
            end
            default: ;
        endcase
    end

    assign o_cur_code = r_cur_code;
    assign o_err_tmo  = r_err_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target   <= CODE_W'(INIT_CODE);
            r_data     <= CODE_W'(INIT_CODE);
            r_cur_code <= CODE_W'(INIT_CODE);
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_err_tmo  <= 1'b0;
        end else begin
            if (w_accept) r_target <= req_if.req_code;

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == WRITE || (r_state == SETTLE && r_cnt != CNT_W'(BLANK_CYC))) begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_tmo <= (r_state == SETTLE) ? r_tmo + 1'b1 : '0;

            // While parked, realign the write port with the last settled code.
            if (r_state == STEP)       r_data <= w_step_code;
            else if (r_state == FAULT) r_data <= r_cur_code;

            if (w_settle_ok && !w_flt_hit) r_cur_code <= r_data;

            if (w_tmo_hit)                                    r_err_tmo <= 1'b1;
            else if (r_state == FAULT && w_state_nxt == IDLE) r_err_tmo <= 1'b0;
        end
    end
endmodule
